// File: rtl/open_list_pop_if.sv
// Handshake bundle between the sorter/expansion logic and the open-list read buffer.
// The master modport is the sorter and consumer side; the slave modport is the buffer.
interface open_list_pop_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned KEY_W = 8,
  parameter int unsigned ID_W  = 8
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic             Load_Start;
  logic             Wr_En;
  logic [KEY_W-1:0] Wr_Key;
  logic [ID_W-1:0]  Wr_Id;
  logic             Load_Done;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [KEY_W-1:0] Out_Key;
  logic [ID_W-1:0]  Out_Id;
  logic [PW-1:0]    Count;
  logic             Empty;
  logic             Busy;
  logic             Order_Err;
  logic             Overflow;

  modport master (
    output Load_Start, Wr_En, Wr_Key, Wr_Id, Load_Done, Out_Ready,
    input  Out_Valid, Out_Key, Out_Id, Count, Empty, Busy, Order_Err, Overflow
  );

  modport slave (
    input  Load_Start, Wr_En, Wr_Key, Wr_Id, Load_Done, Out_Ready,
    output Out_Valid, Out_Key, Out_Id, Count, Empty, Busy, Order_Err, Overflow
  );
endinterface

// File: rtl/open_list_pop.sv
// Sorted open-list buffer: loaded in ascending f-cost order by the sorter,
// served lowest-cost first, with sticky ordering-violation and overflow flags.
module open_list_pop #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned KEY_W = 8,
  parameter int unsigned ID_W  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  open_list_pop_if.slave       bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [PW-1:0] FULL_P = PW'(DEPTH);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [ID_W-1:0]  id;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          order_err_q, order_err_d;
  logic          overflow_q, overflow_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic [AW-1:0] wr_idx, prev_idx, rd_idx;
  logic [PW-1:0] prev_ptr;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign prev_ptr = wr_ptr_q - ONE_P;
  assign prev_idx = prev_ptr[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    order_err_d = order_err_q;
    overflow_d  = overflow_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (bus.Load_Start) begin
      // Abort overrides everything; a simultaneous write becomes entry 0.
      state_d     = LOAD;
      rd_ptr_d    = '0;
      order_err_d = 1'b0;
      overflow_d  = 1'b0;
      if (bus.Wr_En) begin
        mem_d[0] = '{key: bus.Wr_Key, id: bus.Wr_Id};
        wr_ptr_d = ONE_P;
      end else begin
        wr_ptr_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (bus.Wr_En) begin
            if (wr_ptr_q == FULL_P) begin
              overflow_d = 1'b1;
            end else begin
              mem_d[wr_idx] = '{key: bus.Wr_Key, id: bus.Wr_Id};
              wr_ptr_d      = wr_ptr_q + ONE_P;
              if (wr_ptr_q != '0 && bus.Wr_Key < mem_q[prev_idx].key) begin
                order_err_d = 1'b1;
              end
            end
          end
          if (bus.Load_Done) begin
            state_d = (wr_ptr_d != rd_ptr_q) ? SERVE : IDLE;
          end
        end
        SERVE: begin
          if (bus.Out_Ready) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
            if (rd_ptr_d == wr_ptr_q) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      order_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      order_err_q <= order_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    bus.Out_Valid = (state_q == SERVE);
    bus.Out_Key   = bus.Out_Valid ? mem_q[rd_idx].key : '0;
    bus.Out_Id    = bus.Out_Valid ? mem_q[rd_idx].id : '0;
    bus.Count     = wr_ptr_q - rd_ptr_q;
    bus.Empty     = (wr_ptr_q == rd_ptr_q);
    bus.Busy      = (state_q == LOAD);
    bus.Order_Err = order_err_q;
    bus.Overflow  = overflow_q;
  end
endmodule

// File: tb/tb_open_list_pop.sv
// Scoreboard bench for open_list_pop: stimulus queues expected pops, a
// negedge monitor compares every accepted head entry against the queue.
module tb_open_list_pop;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned KEY_W = 8;
  localparam int unsigned ID_W  = 8;

  logic clk;
  logic rst_n;

  open_list_pop_if #(.DEPTH(DEPTH), .KEY_W(KEY_W), .ID_W(ID_W)) bus ();

  open_list_pop #(.DEPTH(DEPTH), .KEY_W(KEY_W), .ID_W(ID_W)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int unsigned vectors;
  int unsigned miscompares;
  logic [15:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge is the pop taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.Out_Valid && bus.Out_Ready && !bus.Load_Start) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got key %0d id %0d, want no pop", bus.Out_Key, bus.Out_Id);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.Out_Key !== e[15:8] || bus.Out_Id !== e[7:0]) begin
          miscompares++;
          $display("FAIL pop_data: got key %0d id %0d, want key %0d id %0d",
                   bus.Out_Key, bus.Out_Id, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.Load_Start = 1'b1;
    exp_q.delete();
    tick();
    bus.Load_Start = 1'b0;
  endtask

  task automatic wr(input logic [7:0] k, input logic [7:0] id, input bit expect_pop);
    bus.Wr_En  = 1'b1;
    bus.Wr_Key = k;
    bus.Wr_Id  = id;
    if (expect_pop) exp_q.push_back({k, id});
    tick();
    bus.Wr_En = 1'b0;
  endtask

  task automatic done();
    bus.Load_Done = 1'b1;
    tick();
    bus.Load_Done = 1'b0;
  endtask

  task automatic pops(input int n);
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.Out_Ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.Load_Start = 1'b0;
    bus.Wr_En      = 1'b0;
    bus.Wr_Key     = '0;
    bus.Wr_Id      = '0;
    bus.Load_Done  = 1'b0;
    bus.Out_Ready  = 1'b0;
    #12;
    check("rst_valid", bus.Out_Valid, 0);
    check("rst_key", bus.Out_Key, 0);
    check("rst_id", bus.Out_Id, 0);
    check("rst_count", bus.Count, 0);
    check("rst_empty", bus.Empty, 1);
    check("rst_busy", bus.Busy, 0);
    check("rst_flags", {bus.Order_Err, bus.Overflow}, 0);
    rst_n = 1'b1;
    tick();

    // Basic ascending list with a duplicate key
    start();
    check("t1_busy", bus.Busy, 1);
    wr(8'd3, 8'd1, 1); wr(8'd5, 8'd2, 1); wr(8'd5, 8'd3, 1); wr(8'd9, 8'd4, 1);
    check("t1_count_loaded", bus.Count, 4);
    done();
    check("t1_valid", bus.Out_Valid, 1);
    check("t1_busy_off", bus.Busy, 0);
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_count_pop", bus.Count, 32'(3 - i));
    end
    bus.Out_Ready = 1'b0;
    check("t1_empty", bus.Empty, 1);
    check("t1_valid_off", bus.Out_Valid, 0);
    check("t1_order", bus.Order_Err, 0);

    // Consumer stall holds the head
    start();
    wr(8'd10, 8'd20, 1); wr(8'd11, 8'd21, 1);
    done();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", bus.Out_Valid, 1);
      check("t2_stall_key", bus.Out_Key, 10);
      check("t2_stall_id", bus.Out_Id, 20);
      check("t2_stall_count", bus.Count, 2);
    end
    pops(2);
    check("t2_empty", bus.Empty, 1);

    // Overflow: 17th write dropped
    start();
    for (int i = 0; i < 16; i++) wr(8'(i + 1), 8'(100 + i), 1);
    check("t3_ovf_before", bus.Overflow, 0);
    wr(8'd200, 8'd200, 0);
    check("t3_ovf", bus.Overflow, 1);
    check("t3_count", bus.Count, 16);
    done();
    pops(16);
    check("t3_empty", bus.Empty, 1);
    check("t3_ovf_hold", bus.Overflow, 1);

    // Ordering violation is flagged but both entries are still served
    start();
    check("t4_ovf_clr", bus.Overflow, 0);
    wr(8'd4, 8'd1, 1);
    check("t4_order_ok", bus.Order_Err, 0);
    wr(8'd2, 8'd2, 1);
    check("t4_order_err", bus.Order_Err, 1);
    done();
    pops(2);
    check("t4_order_hold", bus.Order_Err, 1);
    start();
    check("t4_order_clr", bus.Order_Err, 0);

    // Abort mid-serve with a write in the same cycle; pop in that cycle is discarded
    for (int i = 0; i < 5; i++) wr(8'(20 + i), 8'(50 + i), 1);
    done();
    bus.Out_Ready = 1'b1;
    tick(); tick();
    check("t5_count_mid", bus.Count, 3);
    bus.Load_Start = 1'b1;
    bus.Wr_En = 1'b1; bus.Wr_Key = 8'd7; bus.Wr_Id = 8'd77;
    exp_q.delete();
    exp_q.push_back({8'd7, 8'd77});
    tick();
    bus.Load_Start = 1'b0; bus.Wr_En = 1'b0;
    check("t5_valid_off", bus.Out_Valid, 0);
    check("t5_count", bus.Count, 1);
    check("t5_busy", bus.Busy, 1);
    done();
    tick();
    bus.Out_Ready = 1'b0;
    check("t5_empty", bus.Empty, 1);

    // Empty load, Load_Start beating Load_Done, and async reset mid-load
    start();
    done();
    check("t6_busy_off", bus.Busy, 0);
    check("t6_valid", bus.Out_Valid, 0);
    tick();
    check("t6_valid_idle", bus.Out_Valid, 0);
    bus.Load_Start = 1'b1; bus.Load_Done = 1'b1;
    exp_q.delete();
    tick();
    bus.Load_Start = 1'b0; bus.Load_Done = 1'b0;
    check("t6_start_wins", bus.Busy, 1);
    wr(8'd9, 8'd1, 0); wr(8'd1, 8'd2, 0);
    check("t6_pre_count", bus.Count, 2);
    check("t6_pre_order", bus.Order_Err, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.Busy, 0);
    check("t6_rst_count", bus.Count, 0);
    check("t6_rst_empty", bus.Empty, 1);
    check("t6_rst_order", bus.Order_Err, 0);
    check("t6_rst_valid", bus.Out_Valid, 0);
    rst_n = 1'b1;
    tick(); tick();

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
